// File: rtl/pc_sequencer.sv
// pc_sequencer
//
// Program-counter sequencer for the fetch stage. It produces the fetch
// address and a valid/ready handshake, and handles stall, jump/branch
// redirects, trap entry/return with a saved EPC, misaligned-target detection
// with a halt state, and an accepted-fetch counter.
//
// Parameters:
//   WIDTH        - width of PC, targets, EPC and fetch counter
//   RESET_VECTOR - first PC presented after reset
//   TRAP_VECTOR  - PC loaded on trap entry
//   STEP         - sequential increment
//   ALIGN_BITS   - low target bits that must be zero (0 disables the check)
//
// Ports:
//   clka, rsta            - clock (rising edge), async active-high reset
//   stall                 - freeze request from the hazard unit
//   fetch_ready           - instruction memory accepts pc_out this cycle
//   br_taken, br_target   - taken conditional branch and its destination
//   jmp, jmp_target       - unconditional jump and its destination
//   trap_req, eret        - trap entry request, return from trap
//   pc_out, pc_valid      - fetch address and its valid flag
//   epc_out, in_trap      - saved return address, trap handler active
//   misalign_err          - one-cycle pulse after a misaligned redirect
//   fetch_count           - number of accepted fetches (wraps)

module pc_sequencer #(
  parameter int                 WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]   TRAP_VECTOR  = WIDTH'(32'h0000_0180),
  parameter int                 STEP         = 4,
  parameter int                 ALIGN_BITS   = 2
) (
  input  logic             clka,
  input  logic             rsta,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             trap_req,
  input  logic             eret,
  output logic [WIDTH-1:0] pc_out,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc_out,
  output logic             in_trap,
  output logic             misalign_err,
  output logic [WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  // With ALIGN_BITS = 0 this mask is zero, which disables the check.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             in_trap_q, in_trap_d;
  logic             misalign_q, misalign_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic             fire;
  logic [WIDTH-1:0] redirect_target;
  logic             redirect_misaligned;

  assign fire = (state_q == RUN) & fetch_ready & ~stall;

  // Jump outranks branch, so only the jump target matters when both are set.
  assign redirect_target     = jmp ? jmp_target : br_target;
  assign redirect_misaligned = |(redirect_target & ALIGN_MASK);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    in_trap_d  = in_trap_q;
    misalign_d = 1'b0;
    count_d    = count_q;

    case (state_q)
      BOOT: begin
        // pc_q already holds RESET_VECTOR, so it becomes the first fetch.
        state_d = RUN;
      end

      RUN: begin
        if (fire) begin
          count_d = count_q + WIDTH'(1);
        end

        if (trap_req && !in_trap_q) begin
          epc_d     = pc_q;
          pc_d      = TRAP_VECTOR;
          in_trap_d = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if (eret && in_trap_q) begin
          pc_d      = epc_q;
          in_trap_d = 1'b0;
        end else if (jmp || br_taken) begin
          if (redirect_misaligned) begin
            // Freeze on the current PC; the abandoned fetch is not counted.
            misalign_d = 1'b1;
            state_d    = HALT;
            count_d    = count_q;
          end else begin
            pc_d = redirect_target;
          end
        end else if (fire) begin
          pc_d = pc_q + STEP_W;
        end
      end

      HALT: begin
        // Only a trap leaves HALT, even if a handler was already active.
        if (trap_req) begin
          epc_d     = pc_q;
          pc_d      = TRAP_VECTOR;
          in_trap_d = 1'b1;
          state_d   = RUN;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      in_trap_q  <= 1'b0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      in_trap_q  <= in_trap_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign pc_out       = pc_q;
  assign pc_valid     = (state_q == RUN);
  assign epc_out      = epc_q;
  assign in_trap      = in_trap_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. A 32-bit instance runs the main sequence;
// an 8-bit instance reset to 0xFC with fetch_ready tied high shows the PC
// wrapping to 0x00. Expected outputs are queued with the cycle they are due
// and a separate monitor pops and compares them.

module tb_pc_sequencer;

  logic        clka;
  logic        rsta;
  logic        stall;
  logic        fetch_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic        trap_req;
  logic        eret;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [31:0] epc_out;
  logic        in_trap;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic        s_one;
  logic        s_zero;
  logic [7:0]  s_zero8;
  logic [7:0]  s_pc;
  logic        s_valid;
  logic [7:0]  s_epc;
  logic        s_trap;
  logic        s_mis;
  logic [7:0]  s_cnt;

  typedef struct {
    int          due;
    bit          sel;
    string       name;
    logic [31:0] pc;
    logic        valid;
    logic [31:0] epc;
    logic        trap;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;
  event check_now;

  pc_sequencer dut (
    .clka        (clka),
    .rsta        (rsta),
    .stall       (stall),
    .fetch_ready (fetch_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .trap_req    (trap_req),
    .eret        (eret),
    .pc_out      (pc_out),
    .pc_valid    (pc_valid),
    .epc_out     (epc_out),
    .in_trap     (in_trap),
    .misalign_err(misalign_err),
    .fetch_count (fetch_count)
  );

  pc_sequencer #(
    .WIDTH       (8),
    .RESET_VECTOR(8'hFC),
    .TRAP_VECTOR (8'h80),
    .STEP        (4),
    .ALIGN_BITS  (2)
  ) dut_small (
    .clka        (clka),
    .rsta        (rsta),
    .stall       (s_zero),
    .fetch_ready (s_one),
    .br_taken    (s_zero),
    .br_target   (s_zero8),
    .jmp         (s_zero),
    .jmp_target  (s_zero8),
    .trap_req    (s_zero),
    .eret        (s_zero),
    .pc_out      (s_pc),
    .pc_valid    (s_valid),
    .epc_out     (s_epc),
    .in_trap     (s_trap),
    .misalign_err(s_mis),
    .fetch_count (s_cnt)
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clka);
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_expect(input bit sel, input int due, input string name,
                             input logic [31:0] pc, input logic valid,
                             input logic [31:0] epc, input logic trap,
                             input logic mis, input logic [31:0] cnt);
    exp_t e;
    e.due   = due;
    e.sel   = sel;
    e.name  = name;
    e.pc    = pc;
    e.valid = valid;
    e.epc   = epc;
    e.trap  = trap;
    e.mis   = mis;
    e.cnt   = cnt;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] a_pc, a_epc, a_cnt;
    logic        a_valid, a_trap, a_mis;
    if (e.sel) begin
      a_pc = {24'd0, s_pc}; a_valid = s_valid; a_epc = {24'd0, s_epc};
      a_trap = s_trap; a_mis = s_mis; a_cnt = {24'd0, s_cnt};
    end else begin
      a_pc = pc_out; a_valid = pc_valid; a_epc = epc_out;
      a_trap = in_trap; a_mis = misalign_err; a_cnt = fetch_count;
    end
    checks++;
    if (a_pc !== e.pc || a_valid !== e.valid || a_epc !== e.epc ||
        a_trap !== e.trap || a_mis !== e.mis || a_cnt !== e.cnt) begin
      errors++;
      $display("[TB] FAIL %s: got pc=%h valid=%b epc=%h trap=%b mis=%b cnt=%0d, expected pc=%h valid=%b epc=%h trap=%b mis=%b cnt=%0d",
               e.name, a_pc, a_valid, a_epc, a_trap, a_mis, a_cnt,
               e.pc, e.valid, e.epc, e.trap, e.mis, e.cnt);
    end
  endtask

  // Monitor: compares every queued expectation once its due cycle arrives.
  initial begin
    exp_t e;
    forever begin
      @(negedge clka or check_now);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Drives one cycle of inputs and queues the main DUT's state after the edge.
  task automatic applyStimulus(input string name, input logic st, input logic fr,
                               input logic jp, input logic [31:0] jt,
                               input logic br, input logic [31:0] bt,
                               input logic tr, input logic er,
                               input logic [31:0] e_pc, input logic e_valid,
                               input logic [31:0] e_epc, input logic e_trap,
                               input logic e_mis, input logic [31:0] e_cnt);
    stall       = st;
    fetch_ready = fr;
    jmp         = jp;
    jmp_target  = jt;
    br_taken    = br;
    br_target   = bt;
    trap_req    = tr;
    eret        = er;
    push_expect(1'b0, cyc + 1, name, e_pc, e_valid, e_epc, e_trap, e_mis, e_cnt);
    @(posedge clka);
    #1;
  endtask

  initial begin
    s_one = 1'b1; s_zero = 1'b0; s_zero8 = 8'h00;
    rsta = 1'b1;
    stall = 1'b0; fetch_ready = 1'b0; jmp = 1'b0; jmp_target = '0;
    br_taken = 1'b0; br_target = '0; trap_req = 1'b0; eret = 1'b0;
    checks = 0;
    errors = 0;

    #1;
    push_expect(1'b0, cyc, "reset_main", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    push_expect(1'b1, cyc, "reset_small", 32'hFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    -> check_now;

    repeat (2) @(posedge clka);
    #1;
    rsta = 1'b0;

    //             name           st fr jp jt          br bt          tr er  pc          v  epc       tr mis cnt
    push_expect(1'b1, cyc + 1, "small_boot", 32'hFC, 1'b1, 32'h0, 1'b0, 1'b0, 32'd0);
    applyStimulus("boot",        0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0,   1, 32'h0,  0, 0, 32'd0);
    push_expect(1'b1, cyc + 1, "small_wrap", 32'h00, 1'b1, 32'h0, 1'b0, 1'b0, 32'd1);
    applyStimulus("seq_4",       0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h4,   1, 32'h0,  0, 0, 32'd1);
    push_expect(1'b1, cyc + 1, "small_after_wrap", 32'h04, 1'b1, 32'h0, 1'b0, 1'b0, 32'd2);
    applyStimulus("seq_8",       0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h8,   1, 32'h0,  0, 0, 32'd2);
    applyStimulus("seq_c",       0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'hC,   1, 32'h0,  0, 0, 32'd3);
    applyStimulus("seq_10",      0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h10,  1, 32'h0,  0, 0, 32'd4);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("not_ready", 0, 0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h10,  1, 32'h0,  0, 0, 32'd4);
    end
    applyStimulus("ready_again", 0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h14,  1, 32'h0,  0, 0, 32'd5);
    applyStimulus("seq_18",      0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h18,  1, 32'h0,  0, 0, 32'd6);
    applyStimulus("seq_1c",      0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h1C,  1, 32'h0,  0, 0, 32'd7);
    applyStimulus("seq_20",      0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h20,  1, 32'h0,  0, 0, 32'd8);
    applyStimulus("stall_redir", 1, 1, 1, 32'h100,   1, 32'h200,   0, 0, 32'h20,  1, 32'h0,  0, 0, 32'd8);
    applyStimulus("jmp_over_br", 0, 1, 1, 32'h100,   1, 32'h200,   0, 0, 32'h100, 1, 32'h0,  0, 0, 32'd9);
    applyStimulus("jmp_40",      0, 0, 1, 32'h40,    0, 32'h0,     0, 0, 32'h40,  1, 32'h0,  0, 0, 32'd9);
    applyStimulus("trap_stall",  1, 1, 0, 32'h0,     0, 32'h0,     1, 0, 32'h180, 1, 32'h40, 1, 0, 32'd9);
    applyStimulus("trap_again",  0, 0, 0, 32'h0,     0, 32'h0,     1, 0, 32'h180, 1, 32'h40, 1, 0, 32'd9);
    applyStimulus("trap_eret",   0, 0, 0, 32'h0,     0, 32'h0,     1, 1, 32'h40,  1, 32'h40, 0, 0, 32'd9);
    applyStimulus("eret_no_trap",0, 0, 1, 32'h60,    0, 32'h0,     0, 1, 32'h60,  1, 32'h40, 0, 0, 32'd9);
    applyStimulus("misalign",    0, 1, 0, 32'h0,     1, 32'h102,   0, 0, 32'h60,  0, 32'h40, 0, 1, 32'd9);
    applyStimulus("halt_hold",   0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h60,  0, 32'h40, 0, 0, 32'd9);
    applyStimulus("halt_trap",   0, 1, 0, 32'h0,     0, 32'h0,     1, 0, 32'h180, 1, 32'h60, 1, 0, 32'd9);
    applyStimulus("handler_seq", 0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h184, 1, 32'h60, 1, 0, 32'd10);
    applyStimulus("stall_badjmp",1, 1, 1, 32'h101,   0, 32'h0,     0, 0, 32'h184, 1, 32'h60, 1, 0, 32'd10);
    applyStimulus("eret_fire",   0, 1, 0, 32'h0,     0, 32'h0,     0, 1, 32'h60,  1, 32'h60, 0, 0, 32'd11);
    applyStimulus("trap_enter",  0, 0, 0, 32'h0,     0, 32'h0,     1, 0, 32'h180, 1, 32'h60, 1, 0, 32'd11);

    // Reset mid-trap, between clock edges.
    trap_req = 1'b0;
    @(negedge clka);
    #1;
    rsta = 1'b1;
    #1;
    push_expect(1'b0, cyc, "async_rst_main", 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    push_expect(1'b1, cyc, "async_rst_small", 32'hFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    -> check_now;

    @(posedge clka);
    #1;
    rsta = 1'b0;
    push_expect(1'b1, cyc + 1, "small_reboot", 32'hFC, 1'b1, 32'h0, 1'b0, 1'b0, 32'd0);
    applyStimulus("reboot",      0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0,   1, 32'h0,  0, 0, 32'd0);
    push_expect(1'b1, cyc + 1, "small_rewrap", 32'h00, 1'b1, 32'h0, 1'b0, 1'b0, 32'd1);
    applyStimulus("reboot_seq",  0, 1, 0, 32'h0,     0, 32'h0,     0, 0, 32'h4,   1, 32'h0,  0, 0, 32'd1);

    repeat (2) @(negedge clka);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the R/I-type CPU fetch stage. It replaces the fixed +4 counter with a configurable width, reset vector and step. It adds a valid/ready fetch handshake, stall, branch/jump redirect, a trap/return mechanism with an EPC register, misaligned-target detection with a halt state, and a fetch counter.

Parameters:
WIDTH, 32, bit width of PC, targets, EPC and fetch counter
RESET_VECTOR, 32'h0000_0000, first PC presented after reset
TRAP_VECTOR, 32'h0000_0180, PC loaded on trap entry
STEP, 4, sequential increment
ALIGN_BITS, 2, number of low target bits that must be zero (0 disables the check)

Ports:
clka  input  1  clock, rising edge
rsta  input  1  reset, asynchronous, active-high
stall  input  1  freeze request from the hazard unit
fetch_ready  input  1  instruction memory accepts pc_out this cycle
br_taken  input  1  conditional branch resolved taken
br_target  input  WIDTH  branch destination
jmp  input  1  unconditional jump
jmp_target  input  WIDTH  jump destination
trap_req  input  1  exception/interrupt request
eret  input  1  return from trap
pc_out  output  WIDTH  current fetch address
pc_valid  output  1  pc_out is a valid fetch request
epc_out  output  WIDTH  saved trap return address
in_trap  output  1  trap handler active
misalign_err  output  1  one-cycle pulse on a misaligned redirect
fetch_count  output  WIDTH  number of accepted fetches

Behaviour:
- Reset (async, rsta=1): pc_out=RESET_VECTOR, pc_valid=0, epc_out=0, in_trap=0, misalign_err=0, fetch_count=0, state=BOOT.
- States and transitions:
  - BOOT: first clka edge after rsta falls -> RUN; pc_out unchanged, so RESET_VECTOR is the first fetch address. pc_valid=1 while in RUN only.
  - RUN: normal operation, described below.
  - HALT: pc_valid=0, pc_out held. Exits only on trap_req or rsta.
- fire = pc_valid & fetch_ready & ~stall. fetch_count increments on fire, modulo 2^WIDTH.
- Next-PC priority, evaluated each edge in RUN:
  1. trap_req, if in_trap=0: epc_out<=pc_out, pc_out<=TRAP_VECTOR, in_trap<=1. Ignores stall and fire.
  2. stall: pc_out holds; eret, jmp and br_taken are ignored (upstream holds them).
  3. eret, if in_trap=1: pc_out<=epc_out, in_trap<=0.
  4. jmp: pc_out<=jmp_target.
  5. br_taken: pc_out<=br_target.
  6. fire: pc_out<=pc_out+STEP, truncated to WIDTH (wraps from all-ones region to low addresses).
  7. Otherwise: hold pc_out; the handshake waits for fetch_ready.
- Redirects (3-5) take effect whether or not fire occurs; the in-flight address is abandoned.
- trap_req while in_trap=1: ignored; the state machine continues with priority 2.
- eret while in_trap=0: ignored; continues with priority 4.
- trap_req and eret in the same cycle with in_trap=1: trap ignored, eret taken.
- Misalignment (ALIGN_BITS>0): the selected jmp_target/br_target has any low ALIGN_BITS bit set. Then pc_out holds, misalign_err=1 for exactly that following cycle, state<=HALT. fetch_count does not increment that cycle.
- HALT + trap_req: epc_out<=pc_out (the address at the time of halt), pc_out<=TRAP_VECTOR, in_trap<=1, state<=RUN, regardless of the prior in_trap value.
- Trap or eret never checks alignment.
- rsta asserted mid-operation, including in HALT or in_trap: all registers return to reset values immediately, without waiting for clka.

Test Plan:
- Reset release, fetch_ready=1, defaults: pc_out 0x0 (pc_valid=0 one cycle), then 0x0, 0x4, 0x8 accepted; fetch_count=3 after three fires.
- fetch_ready=0 for 3 cycles at pc_out 0x10 -> pc_out holds 0x10, fetch_count unchanged; fetch_ready=1 -> 0x14 next cycle.
- At 0x20: jmp=1, jmp_target=0x100 and br_taken=1, br_target=0x200 together -> pc_out=0x100. With stall=1 the same inputs leave pc_out at 0x20.
- At 0x40: trap_req=1 with stall=1 -> pc_out=0x180, epc_out=0x40, in_trap=1. A second trap_req is ignored. eret -> pc_out=0x40, in_trap=0.
- br_taken with br_target=0x102 -> misalign_err pulses 1 cycle, pc_valid=0, pc_out frozen. Then trap_req -> pc_out=0x180, epc_out=frozen PC, pc_valid=1.
- WIDTH=8, STEP=4, pc_out=0xFC, fire -> pc_out=0x00. rsta pulse mid-trap -> in_trap=0, epc_out=0, pc_out=RESET_VECTOR asynchronously.
